// File: rtl/pattern_recorder_pkg.sv
// pattern_recorder_pkg: colour codes, recorder states and colour-to-LED one-hot helper
package pattern_recorder_pkg;
  typedef enum logic [1:0] {COL_B = 2'b00, COL_G = 2'b01, COL_R = 2'b10, COL_Y = 2'b11} color_e;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RECORD = 2'b01, ST_READY = 2'b10} state_e;
  function automatic logic [3:0] color_onehot(logic [1:0] c);
    return 4'b0001 << c;
  endfunction
endpackage

// File: rtl/pattern_recorder_edge.sv
// pattern_recorder_edge: one-cycle pulse on each rising edge of the press level
module pattern_recorder_edge (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic press_i,
  output logic rise_o
);
  logic press_q;
  // remember last cycle's press level
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) press_q <= 1'b0;
    else press_q <= press_i;
  assign rise_o = press_i & ~press_q;
endmodule

// File: rtl/pattern_recorder.sv
// pattern_recorder: records player colour presses and replays them per read strobe; PATTERN_RECORDER_ECHO_EN adds LED echo
module pattern_recorder
  import pattern_recorder_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             start_i,
  input  logic [1:0]       color_i,
  input  logic             press_i,
  input  logic             done_i,
  input  logic             rd_en_i,
  input  logic             rd_rst_i,
  output logic [1:0]       color_o,
  output logic             rd_last_o,
  output logic [LEN_W-1:0] length_o,
  output logic             rec_busy_o,
  output logic             seq_valid_o,
  output logic             full_o,
  output logic [3:0]       led_echo_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  state_e           state_q;
  logic [1:0]       mem_q [DEPTH];
  logic [LEN_W-1:0] len_q, rd_ptr_q;
  logic [1:0]       color_q;
  logic             last_q, full_q;
  logic             rise, wr_en, rd_wrap;
  pattern_recorder_edge u_edge (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .press_i  (press_i),
    .rise_o   (rise)
  );
  // start outranks a same-cycle press; writes stop at DEPTH with no wrap
  assign wr_en   = (state_q == ST_RECORD) && !start_i && rise && (len_q != MAX_LEN);
  assign rd_wrap = rd_ptr_q == len_q - ONE;
  // recorder FSM, sequence buffer and replay outputs
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      rd_ptr_q <= '0;
      color_q  <= '0;
      last_q   <= 1'b0;
      full_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (start_i) begin
      state_q  <= ST_RECORD;
      len_q    <= '0;
      rd_ptr_q <= '0;
      color_q  <= '0;
      last_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[len_q[IDX_W-1:0]] <= color_i;
        len_q  <= len_q + ONE;
        full_q <= (len_q + ONE) == MAX_LEN;
      end
      if (state_q == ST_RECORD && done_i) begin
        state_q  <= (len_q != '0 || wr_en) ? ST_READY : ST_IDLE;
        rd_ptr_q <= '0;
      end
      if (state_q == ST_READY) begin
        if (rd_rst_i) rd_ptr_q <= '0;
        else if (rd_en_i) begin
          color_q  <= mem_q[rd_ptr_q[IDX_W-1:0]];
          last_q   <= rd_wrap;
          rd_ptr_q <= rd_wrap ? '0 : rd_ptr_q + ONE;
        end
      end
    end
  end
  assign color_o     = color_q;
  assign rd_last_o   = last_q;
  assign length_o    = len_q;
  assign full_o      = full_q;
  assign rec_busy_o  = state_q == ST_RECORD;
  assign seq_valid_o = state_q == ST_READY;
`ifdef PATTERN_RECORDER_ECHO_EN
  logic [3:0] led_q;
  // one-hot echo of the last accepted colour, cleared by start
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) led_q <= '0;
    else if (start_i) led_q <= '0;
    else if (wr_en) led_q <= color_onehot(color_i);
  assign led_echo_o = led_q;
`else
  assign led_echo_o = 4'b0000;
`endif
endmodule
